// File: rtl/id_stage.sv
// id_stage: instruction decode with register file, control decode, load-use stall and flush bubbling
//   clk, rst            : clock and synchronous active-high reset
//   instr, PCinc        : instruction and PC+4 from IF/ID
//   regWrite, writeReg, writeData : write-back port from WB
//   exMemRead, exRt     : MemRead and rt currently held in ID/EX, used for load-use detection
//   flush               : squash the instruction in ID
//   idEx                : packed ID/EX bus {rs, PCinc, read1, read2, imm, rd, rt, wb, mem, exe3..exe0}
//   pcWrite, ifidWrite  : update enables, low while stalling
//   stallCount          : saturating count of load-use stall cycles
module id_stage (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  instr,
    input  logic [31:0]  PCinc,
    input  logic         regWrite,
    input  logic [4:0]   writeReg,
    input  logic [31:0]  writeData,
    input  logic         exMemRead,
    input  logic [4:0]   exRt,
    input  logic         flush,
    output logic [151:0] idEx,
    output logic         pcWrite,
    output logic         ifidWrite,
    output logic [15:0]  stallCount
);
    logic [31:0] regs [32];
    logic [5:0]  op;
    logic [4:0]  rs, rt, rd;
    logic [31:0] read1, read2, imm;
    logic [8:0]  ctrl;
    logic        wen, uses_rt, hazard;

    assign op  = instr[31:26];
    assign rs  = instr[25:21];
    assign rt  = instr[20:16];
    assign rd  = instr[15:11];
    assign imm = {{16{instr[15]}}, instr[15:0]};

    // {RegWrite, MemtoReg, Branch, MemRead, MemWrite, RegDst, ALUOp[1:0], ALUSrc}
    assign ctrl = op == 6'h00 ? 9'b10_000_1100 :
                  op == 6'h23 ? 9'b11_010_0001 :
                  op == 6'h2B ? 9'b00_001_0001 :
                  op == 6'h04 ? 9'b00_100_0010 :
                  op == 6'h08 ? 9'b10_000_0001 : 9'b0;

    // Writes to $0 and writes during reset are dropped, and the bypass follows the same rule
    assign wen   = regWrite && writeReg != 5'd0 && !rst;
    assign read1 = rs == 5'd0 ? 32'd0 : (wen && writeReg == rs) ? writeData : regs[rs];
    assign read2 = rt == 5'd0 ? 32'd0 : (wen && writeReg == rt) ? writeData : regs[rt];

    // Only R-type, sw and beq actually consume rt as a source operand
    assign uses_rt = op == 6'h00 || op == 6'h2B || op == 6'h04;
    assign hazard  = exMemRead && exRt != 5'd0 && (exRt == rs || (uses_rt && exRt == rt));

    assign pcWrite   = !hazard;
    assign ifidWrite = !hazard;
    assign idEx      = {rs, PCinc, read1, read2, imm, rd, rt,
                        (hazard || flush || rst) ? 9'b0 : ctrl};

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
            stallCount <= 16'd0;
        end else begin
            if (wen) regs[writeReg] <= writeData;
            if (hazard && stallCount != 16'hFFFF) stallCount <= stallCount + 16'd1;
        end
    end
endmodule
